// File: rtl/morse_classify_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_classify_if
// Description : Recorder-to-classifier bus: five latched durations plus the
//               end-of-message level in, element code/count/status out.
// Revision    : 1.0
// ============================================================================
interface morse_classify_if #(
    parameter int WID = 32
);
    logic [5*WID-1:0] value;
    logic             m_end;
    logic [4:0]       code;
    logic [2:0]       len;
    logic             err;
    logic             valid;
    logic             busy;

    modport master (
        output value, m_end,
        input  code, len, err, valid, busy
    );

    modport slave (
        input  value, m_end,
        output code, len, err, valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/morse_classify.sv
`default_nettype none
// ============================================================================
// Module      : morse_classify
// Description : Classifies five recorded pulse durations as dot/dash against
//               a threshold of twice the shortest pulse (capped at UNIT_MAX).
// Revision    : 1.0
// ============================================================================
module morse_classify #(
    parameter int WID      = 32,
    parameter int UNIT_MAX = 12
) (
    input  wire logic       clk,
    input  wire logic       reset,
    morse_classify_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MIN   = 2'd1,
        S_CLASS = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WID:0] c_UNIT_CAP = (WID+1)'(UNIT_MAX);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [WID-1:0] r_slot [0:4];
    logic [2:0]     r_idx;
    logic [WID-1:0] r_min;
    logic [2:0]     r_len_s;
    logic           r_err_s;
    logic           r_gap;
    logic [4:0]     r_code_s;
    logic           r_m_end_d;
    logic [4:0]     r_code;
    logic [2:0]     r_len;
    logic           r_err;

    logic           w_start;
    logic           w_last;
    logic [WID-1:0] w_cur;
    logic [WID:0]   w_ref;
    logic [WID:0]   w_thresh;
    logic           w_dash;
    logic [4:0]     w_code_nxt;
    logic           w_busy;
    logic           w_valid;

    assign w_start    = bus.m_end & ~r_m_end_d;
    assign w_last     = (r_idx == 3'd4);
    assign w_cur      = r_slot[r_idx];
    // One extra bit so doubling an all-ones min cannot wrap
    assign w_ref      = ({1'b0, r_min} > c_UNIT_CAP) ? c_UNIT_CAP : {1'b0, r_min};
    assign w_thresh   = w_ref << 1;
    assign w_dash     = (r_idx < r_len_s) && ({1'b0, w_cur} > w_thresh);
    assign w_code_nxt = r_code_s | (w_dash ? (5'd1 << r_idx) : 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_MIN;
            end
            S_MIN: begin
                w_busy = 1'b1;
                if (w_last) w_state_nxt = S_CLASS;
            end
            S_CLASS: begin
                w_busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) r_slot[i] <= '0;
            r_idx     <= 3'd0;
            r_min     <= '1;
            r_len_s   <= 3'd0;
            r_err_s   <= 1'b0;
            r_gap     <= 1'b0;
            r_code_s  <= 5'd0;
            r_m_end_d <= 1'b1;
            r_code    <= 5'd0;
            r_len     <= 3'd0;
            r_err     <= 1'b0;
        end else begin
            r_m_end_d <= bus.m_end;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        for (int i = 0; i < 5; i++) r_slot[i] <= bus.value[WID*i +: WID];
                        r_idx    <= 3'd0;
                        r_min    <= '1;
                        r_len_s  <= 3'd0;
                        r_err_s  <= 1'b0;
                        r_gap    <= 1'b0;
                        r_code_s <= 5'd0;
                    end
                end
                S_MIN: begin
                    if (w_cur != '0) begin
                        if (w_cur < r_min) r_min <= w_cur;
                        // A pulse after an empty slot breaks the prefix
                        if (r_gap) r_err_s <= 1'b1;
                        else       r_len_s <= r_len_s + 3'd1;
                    end else begin
                        r_gap <= 1'b1;
                    end
                    r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
                end
                S_CLASS: begin
                    r_code_s <= w_code_nxt;
                    r_idx    <= w_last ? 3'd0 : r_idx + 3'd1;
                    // Publish on entry to DONE so results line up with valid
                    if (w_last) begin
                        r_code <= w_code_nxt;
                        r_len  <= r_len_s;
                        r_err  <= r_err_s | (r_len_s == 3'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.code  = r_code;
    assign bus.len   = r_len;
    assign bus.err   = r_err;
    assign bus.valid = w_valid;
    assign bus.busy  = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_morse_classify.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_classify
// Description : Directed and randomized checks of morse_classify against a
//               behavioural dot/dash model.
// Revision    : 1.0
// ============================================================================
module tb_morse_classify;
    localparam int WID      = 32;
    localparam int UNIT_MAX = 12;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;

    morse_classify_if #(.WID(WID)) bus ();

    morse_classify #(.WID(WID), .UNIT_MAX(UNIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5*WID-1:0] pk(input longint a, b, c, d, e);
        return {WID'(e), WID'(d), WID'(c), WID'(b), WID'(a)};
    endfunction

    // Reference: leading nonzero prefix, gap => error, threshold 2*min(shortest, cap)
    function automatic void model(input logic [5*WID-1:0] v, output logic [4:0] c,
                                  output logic [2:0] l, output logic e);
        longint s [5];
        longint mn, thr;
        int     n = 0;
        bit     seen_zero = 0;
        e  = 1'b0;
        mn = -1;
        for (int i = 0; i < 5; i++) s[i] = longint'(v[WID*i +: WID]);
        for (int i = 0; i < 5; i++) begin
            if (s[i] == 0) seen_zero = 1;
            else begin
                if (seen_zero) e = 1'b1;
                else n++;
                if (mn < 0 || s[i] < mn) mn = s[i];
            end
        end
        if (mn < 0 || mn > UNIT_MAX) mn = UNIT_MAX;
        thr = 2 * mn;
        c = 5'd0;
        for (int i = 0; i < n; i++) c[i] = (s[i] > thr);
        l = 3'(n);
        e = e | (n == 0);
    endfunction

    task automatic decode(input string tag, input logic [5*WID-1:0] v,
                          input bit scramble, input bit hold);
        logic [4:0] ec;
        logic [2:0] el;
        logic       ee;
        int         lat;
        bit         busy_ok;
        model(v, ec, el, ee);
        @(negedge clk);
        bus.value = v;
        bus.m_end = 1'b1;
        @(posedge clk); #1;
        lat     = 0;
        busy_ok = 1;
        while (bus.valid !== 1'b1 && lat < 30) begin
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (scramble && lat == 3) bus.value = {$urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 10);
        check({tag, "_busy"}, {31'd0, busy_ok}, 1);
        check({tag, "_busy_done"}, {31'd0, bus.busy}, 0);
        check({tag, "_code"}, {27'd0, bus.code}, {27'd0, ec});
        check({tag, "_len"}, {29'd0, bus.len}, {29'd0, el});
        check({tag, "_err"}, {31'd0, bus.err}, {31'd0, ee});
        @(posedge clk); #1;
        check({tag, "_strobe"}, {31'd0, bus.valid}, 0);
        if (!hold) begin
            @(negedge clk);
            bus.m_end = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5*WID-1:0] v;
        int nv;

        bus.value = '0;
        bus.m_end = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", {27'd0, bus.code}, 0);
        check("rst_len", {29'd0, bus.len}, 0);
        check("rst_err", {31'd0, bus.err}, 0);
        check("rst_valid", {31'd0, bus.valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        decode("A", pk(10, 30, 0, 0, 0), 0, 0);
        check("A_code_lit", {27'd0, bus.code}, 32'b00010);
        decode("O", pk(30, 31, 29, 0, 0), 0, 0);
        check("O_code_lit", {27'd0, bus.code}, 32'b00111);
        decode("five", pk(10, 11, 9, 10, 12), 0, 0);
        check("five_len_lit", {29'd0, bus.len}, 5);
        decode("equal_thresh", pk(9, 18, 19, 0, 0), 0, 0);
        check("equal_thresh_lit", {27'd0, bus.code}, 32'b00100);
        decode("gap", pk(10, 0, 30, 0, 0), 0, 0);
        decode("empty", pk(0, 0, 0, 0, 0), 0, 0);
        check("empty_err_lit", {31'd0, bus.err}, 1);
        decode("big", pk(64'hFFFF_FFFF, 5, 64'h8000_0000, 0, 0), 0, 0);

        decode("scramble", pk(12, 40, 11, 36, 0), 1, 0);

        // m_end held high: only the first edge counts
        decode("hold", pk(8, 24, 8, 0, 0), 0, 1);
        nv = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) nv++;
        end
        check("hold_extra_valid", nv, 0);
        @(negedge clk);
        bus.m_end = 1'b0;

        // Reset while m_end stays high must not trigger a decode
        @(negedge clk);
        bus.m_end = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1 || bus.busy === 1'b1) nv++;
        end
        check("rst_high_no_decode", nv, 0);
        @(negedge clk);
        bus.m_end = 1'b0;
        decode("after_rst_high", pk(7, 21, 7, 21, 0), 0, 0);

        // Abort mid-decode with reset during the fourth busy cycle
        @(negedge clk);
        bus.value = pk(10, 30, 30, 0, 0);
        bus.m_end = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", {31'd0, bus.valid}, 0);
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_code", {27'd0, bus.code}, 0);
        check("abort_len", {29'd0, bus.len}, 0);
        check("abort_err", {31'd0, bus.err}, 0);
        @(negedge clk);
        reset     = 1'b0;
        bus.m_end = 1'b0;
        nv = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) nv++;
        end
        check("abort_no_valid", nv, 0);
        decode("after_abort", pk(10, 30, 30, 0, 0), 0, 0);

        // Randomized messages: dots ~1 unit, dashes ~3 units, occasional gaps
        for (int t = 0; t < 60; t++) begin
            int unit, n;
            longint s;
            unit = $urandom_range(1, 16);
            n    = $urandom_range(0, 5);
            v    = '0;
            for (int i = 0; i < 5; i++) begin
                if (i < n || $urandom_range(0, 5) == 0) begin
                    s = ($urandom_range(0, 1) == 1) ? 3 * unit : unit;
                    s = s + $urandom_range(0, 2);
                    if ($urandom_range(0, 15) == 0) s = longint'($urandom);
                    if (s == 0) s = 1;
                end else begin
                    s = 0;
                end
                v[WID*i +: WID] = WID'(s);
            end
            decode("rand", v, t % 7 == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
